stub_hit_scheduler: RTL
=======================

# stub_hit_scheduler

Synthesizable, parametrised stub-hit source for the track-trigger test bench. It accepts timestamped stub records over a ready/valid stream and keeps only those addressed to this front-end (layer/phi/z/fe). It buffers them in an in-order FIFO and, on each bunch crossing (BX), emits up to N_HITS stubs whose timestamp equals the current BX counter on parallel hit slots. Late and excess stubs are counted rather than silently lost.

## Interface
- N_HITS, 3: number of parallel hit output slots (1..8).
- STUB_W, 8: stub address width.
- BEND_W, 5: bend width; DATA_W = STUB_W+BEND_W.
- TS_W, 32: timestamp / BX counter width.
- DEPTH, 16: FIFO depth in records, power of 2, ≥ N_HITS+1.
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  BX strobe; each high cycle is one BX.
- layer  in  6  this block's layer address (quasi-static).
- phi  in  4  phi address.
- z  in  4  z address.
- fe  in  3  front-end address.
- rec_valid  in  1  input record valid.
- rec_ready  out  1  input record accepted when valid&ready.
- rec_ts  in  TS_W  record BX timestamp.
- rec_layer, rec_phi, rec_z, rec_fe  in  6/4/4/3  record address.
- rec_stub  in  STUB_W  stub address.
- rec_bend  in  BEND_W  bend.
- hit_dv  out  N_HITS  per-slot data valid.
- hit_data  out  N_HITS*DATA_W  slot i at [i*DATA_W +: DATA_W] = {stub,bend}.
- hit_ts  out  TS_W  BX of the current outputs.
- hit_ovf  out  1  pulse: more than N_HITS stubs matched this BX.
- ts_cnt  out  TS_W  current BX counter.
- late_cnt  out  16  saturating count of discarded late records.
- ovf_cnt  out  16  saturating count of BXs with hit_ovf.
- fifo_level  out  log2(DEPTH)+1  occupied entries.

## Operation
- Write filter: a record is consumed when rec_valid&rec_ready. It is written to the FIFO (entry {ts,stub,bend}) only if all four address fields equal the inputs. Non-matching records are consumed and dropped.
- rec_ready = FIFO not full. Non-matching records are also stalled when the FIFO is full.
- Records arrive in non-decreasing rec_ts order. This ordering is a source obligation and is not checked.
- BX processing, on a cycle with en=1 and T = ts_cnt:
  - Examine head entries 0..N_HITS-1 that are occupied. Pop the longest consecutive prefix with ts ≤ T.
  - Popped entries with ts == T fill slots 0,1,… in FIFO order and set hit_dv bits.
  - Popped entries with ts < T are late. late_cnt += number late, saturating at 16'hFFFF.
  - If N_HITS entries with ts == T were popped and entry N_HITS exists with ts == T, set hit_ovf and increment ovf_cnt. That entry stays in the FIFO and is counted late on the next BX.
  - An entry with ts > T stops the scan. It and all later entries stay in the FIFO.
- ts_cnt increments by 1 after every en cycle and wraps modulo 2^TS_W. After the wrap, comparison is plain unsigned.
- Cycles with en=0: no pops; hit_dv=0, hit_ovf=0; hit_data and hit_ts hold.
- Simultaneous push and pop in one cycle is supported. fifo_level = level + pushes − pops.

## Timing
- Reset (rst_n low, asynchronous): FIFO empty, rec_ready=1 after release, ts_cnt=0, hit_dv=0, hit_data=0, hit_ts=0, hit_ovf=0, late_cnt=0, ovf_cnt=0, fifo_level=0.
- Reset mid-operation discards all buffered records and zeroes all outputs immediately.
- A record accepted at edge k is visible to a BX evaluated at edge k+1 or later. It is not visible to a BX at edge k.
- hit_dv, hit_data, hit_ts, hit_ovf are registered. A BX sampled at edge k drives outputs valid after edge k, for one cycle (until edge k+1).
- ts_cnt updates at the same edge; hit_ts = old ts_cnt.
- rec_ready is derived from the registered level only, with no combinational path from rec_valid. A pop at edge k frees space visible at cycle k+1.
- Counters saturate and never wrap.

## Test plan
- Reset, then fe=3 and records (ts=2,stub=8'h11,bend=5'h04) ×2 for fe=3, en held high → at BX T=2, hit_dv=3'b011, slot0=slot1=13'h0224, hit_ts=2; all other BXs hit_dv=0.
- Four matching records at ts=5, N_HITS=3 → BX5: hit_dv=3'b111, hit_ovf=1, ovf_cnt=1. BX6: hit_dv=0, late_cnt=1, fifo_level=0.
- Record for fe=2 while fe=3 → accepted (rec_ready=1), fifo_level stays 0, no hit ever emitted.
- en low until ts_cnt would be 0, record ts=0 loaded, then en pulses at cycles 10 and 20 → only cycle 10 BX emits, hit_ts=0. ts_cnt=1 after cycle 10 and 2 after cycle 20.
- Fill 16 matching records with ts=100 and en=0 → rec_ready=0 at level 16. A 17th record is stalled, not lost. Enable BXs: after BX100 level drops by 3 and rec_ready returns to 1 the next cycle.
- Reset pulse asserted mid-stream with 5 buffered records → all outputs and fifo_level 0 immediately. No hits emitted after release until new records arrive.

Source files
------------

// File: rtl/stub_hit_scheduler_if.sv
// Record input stream and parallel hit output bundle of stub_hit_scheduler.
// slave: the scheduler side; master: the record source / hit consumer side.
interface stub_hit_scheduler_if #(
  parameter int N_HITS = 3,
  parameter int STUB_W = 8,
  parameter int BEND_W = 5,
  parameter int TS_W   = 32
);
  localparam int DATA_W = STUB_W + BEND_W;

  logic                     rec_valid;
  logic                     rec_ready;
  logic [TS_W-1:0]          rec_ts;
  logic [5:0]               rec_layer;
  logic [3:0]               rec_phi;
  logic [3:0]               rec_z;
  logic [2:0]               rec_fe;
  logic [STUB_W-1:0]        rec_stub;
  logic [BEND_W-1:0]        rec_bend;

  logic [N_HITS-1:0]        hit_dv;
  logic [N_HITS*DATA_W-1:0] hit_data;
  logic [TS_W-1:0]          hit_ts;
  logic                     hit_ovf;

  modport master (
    output rec_valid, rec_ts, rec_layer, rec_phi, rec_z, rec_fe, rec_stub, rec_bend,
    input  rec_ready, hit_dv, hit_data, hit_ts, hit_ovf
  );

  modport slave (
    input  rec_valid, rec_ts, rec_layer, rec_phi, rec_z, rec_fe, rec_stub, rec_bend,
    output rec_ready, hit_dv, hit_data, hit_ts, hit_ovf
  );
endinterface

// File: rtl/stub_hit_scheduler.sv
// Filters timestamped stub records for this front-end into an in-order FIFO and,
// on each BX strobe, emits up to N_HITS stubs whose timestamp equals the BX counter.
module stub_hit_scheduler #(
  parameter int N_HITS = 3,
  parameter int STUB_W = 8,
  parameter int BEND_W = 5,
  parameter int TS_W   = 32,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic [5:0]             layer_i,
  input  logic [3:0]             phi_i,
  input  logic [3:0]             z_i,
  input  logic [2:0]             fe_i,
  stub_hit_scheduler_if.slave    rec_if,
  output logic [TS_W-1:0]        ts_cnt_o,
  output logic [15:0]            late_cnt_o,
  output logic [15:0]            ovf_cnt_o,
  output logic [$clog2(DEPTH):0] fifo_level_o
);
  localparam int DATA_W = STUB_W + BEND_W;
  localparam int ENT_W  = TS_W + DATA_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int LVL_W  = AW + 1;

  logic [ENT_W-1:0]         mem_q [DEPTH];
  logic [AW-1:0]            wr_ptr_q;
  logic [AW-1:0]            rd_ptr_q;
  logic [LVL_W-1:0]         level_q;
  logic [LVL_W-1:0]         level_d;
  logic                     ready_q;
  logic [TS_W-1:0]          ts_cnt_q;
  logic [N_HITS-1:0]        hit_dv_q;
  logic [N_HITS*DATA_W-1:0] hit_data_q;
  logic [TS_W-1:0]          hit_ts_q;
  logic                     hit_ovf_q;
  logic [15:0]              late_cnt_q;
  logic [15:0]              late_cnt_d;
  logic [15:0]              ovf_cnt_q;
  logic [15:0]              ovf_cnt_d;

  logic                     addr_match_s;
  logic                     push_s;
  logic [3:0]               pop_s;
  logic [N_HITS:0]          head_occ_s;
  logic [TS_W-1:0]          head_ts_s   [N_HITS+1];
  logic [DATA_W-1:0]        head_data_s [N_HITS+1];
  logic                     scan_s;
  logic [3:0]               n_pop_s;
  logic [3:0]               n_late_s;
  logic [3:0]               n_hit_s;
  logic [N_HITS*DATA_W-1:0] slot_data_s;
  logic [N_HITS-1:0]        slot_dv_s;
  logic                     ovf_s;
  logic [16:0]              late_sum_s;

  // Head window: the N_HITS candidates plus the one behind them for overflow detection.
  always_comb begin
    for (int i = 0; i <= N_HITS; i++) begin
      head_occ_s[i]  = (LVL_W'(i) < level_q);
      head_ts_s[i]   = mem_q[rd_ptr_q + AW'(i)][ENT_W-1 -: TS_W];
      head_data_s[i] = mem_q[rd_ptr_q + AW'(i)][DATA_W-1:0];
    end
  end

  // BX scan: pop the due prefix, packing on-time stubs into slots in FIFO order.
  always_comb begin
    scan_s      = 1'b1;
    n_pop_s     = 4'd0;
    n_late_s    = 4'd0;
    n_hit_s     = 4'd0;
    slot_data_s = '0;
    slot_dv_s   = '0;
    for (int i = 0; i < N_HITS; i++) begin
      if (scan_s && head_occ_s[i] && (head_ts_s[i] <= ts_cnt_q)) begin
        n_pop_s = n_pop_s + 4'd1;
        if (head_ts_s[i] == ts_cnt_q) begin
          slot_data_s = slot_data_s | ((N_HITS*DATA_W)'(head_data_s[i]) << (n_hit_s * DATA_W));
          slot_dv_s   = slot_dv_s | (N_HITS'(1) << n_hit_s);
          n_hit_s     = n_hit_s + 4'd1;
        end else begin
          n_late_s = n_late_s + 4'd1;
        end
      end else begin
        scan_s = 1'b0;
      end
    end
    ovf_s = (n_hit_s == 4'(N_HITS)) && head_occ_s[N_HITS] && (head_ts_s[N_HITS] == ts_cnt_q);
  end

  // Write filter, FIFO occupancy and saturating statistics.
  always_comb begin
    addr_match_s = (rec_if.rec_layer == layer_i) && (rec_if.rec_phi == phi_i) &&
                   (rec_if.rec_z == z_i) && (rec_if.rec_fe == fe_i);
    push_s       = rec_if.rec_valid && ready_q && addr_match_s;
    pop_s        = en_i ? n_pop_s : 4'd0;
    level_d      = level_q + LVL_W'(push_s) - LVL_W'(pop_s);
    late_sum_s   = {1'b0, late_cnt_q} + 17'(en_i ? n_late_s : 4'd0);
    late_cnt_d   = late_sum_s[16] ? 16'hFFFF : late_sum_s[15:0];
    if (en_i && ovf_s && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Control, counters and registered hit outputs; hit data/ts hold between BXs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b1;
      ts_cnt_q   <= '0;
      hit_dv_q   <= '0;
      hit_data_q <= '0;
      hit_ts_q   <= '0;
      hit_ovf_q  <= 1'b0;
      late_cnt_q <= 16'd0;
      ovf_cnt_q  <= 16'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_q + AW'(push_s);
      rd_ptr_q   <= rd_ptr_q + AW'(pop_s);
      level_q    <= level_d;
      ready_q    <= (level_d != LVL_W'(DEPTH));
      late_cnt_q <= late_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
      if (en_i) begin
        ts_cnt_q   <= ts_cnt_q + TS_W'(1);
        hit_dv_q   <= slot_dv_s;
        hit_data_q <= slot_data_s;
        hit_ts_q   <= ts_cnt_q;
        hit_ovf_q  <= ovf_s;
      end else begin
        hit_dv_q  <= '0;
        hit_ovf_q <= 1'b0;
      end
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {rec_if.rec_ts, rec_if.rec_stub, rec_if.rec_bend};
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign rec_if.rec_ready = ready_q;
  assign rec_if.hit_dv    = hit_dv_q;
  assign rec_if.hit_data  = hit_data_q;
  assign rec_if.hit_ts    = hit_ts_q;
  assign rec_if.hit_ovf   = hit_ovf_q;
  assign ts_cnt_o         = ts_cnt_q;
  assign late_cnt_o       = late_cnt_q;
  assign ovf_cnt_o        = ovf_cnt_q;
  assign fifo_level_o     = level_q;
endmodule
